skew_input_feeder: RTL and testbench

//  Upstream feeder for the ROW x COL systolic array. Accepts one ROW-wide input vector per beat from the

---
 rtl/skew_input_feeder_if.sv | 27 ++
 rtl/skew_input_feeder.sv | 170 +++++++++++++++++
 tb/tb_skew_input_feeder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/skew_input_feeder_if.sv
// skew_input_feeder_if
//   Vector handshake from the input-buffer read path into the skew feeder.
//   Signals:
//     vec_valid  producer -> feeder  input vector valid
//     vec_ready  feeder -> producer  feeder can accept a vector this cycle
//     vec_data   producer -> feeder  ROW x WIDTH vector, element [r] goes to array row r
//   Modports: master = input-buffer side, slave = feeder side.
interface skew_input_feeder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROW   = 4
);
  logic                      vec_valid;
  logic                      vec_ready;
  logic [ROW-1:0][WIDTH-1:0] vec_data;

  modport master (
    output vec_valid,
    output vec_data,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_data,
    output vec_ready
  );
endinterface

// File: rtl/skew_input_feeder.sv
// skew_input_feeder
//   Upstream feeder for a ROW x COL systolic array. Accepts one ROW-wide vector per beat and
//   drives the array row inputs with diagonal skew (row r delayed r cycles), then zero-fills for
//   ROW-1 cycles to drain the wavefront and pulses done_o.
//   Optional build macro: SKEW_FEEDER_STATS_EN adds bubble_cnt_o (FEED cycles without a valid
//   vector, saturating, cleared on accepted start).
// Ports:
//   clk_i        clock, rising edge
//   rstn_i       asynchronous active-low reset
//   start_i      job start pulse, sampled only in idle
//   len_i        vectors in job, sampled with start_i
//   vec_if       slave side of the vector valid/ready handshake
//   ib_data_o    skewed data to array row inputs (zero when the row slot is empty)
//   row_vld_o    per-row valid of ib_data_o[r]
//   busy_o       high while feeding or draining
//   done_o       one-cycle pulse at job end
//   bubble_cnt_o (SKEW_FEEDER_STATS_EN only) feed cycles with no valid vector
module skew_input_feeder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ROW     = 4,
  parameter int unsigned MAX_LEN = 256,
  localparam int unsigned LW     = $clog2(MAX_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic [LW-1:0]             len_i,
  skew_input_feeder_if.slave        vec_if,
  output logic [ROW-1:0][WIDTH-1:0] ib_data_o,
  output logic [ROW-1:0]            row_vld_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef SKEW_FEEDER_STATS_EN
  ,
  output logic [15:0]               bubble_cnt_o
`endif
);

  localparam int unsigned DW = (ROW > 1) ? $clog2(ROW) : 1;
  // Last drain-counter value; unused when ROW == 1 because drain is skipped.
  localparam logic [DW-1:0] DrnLast = DW'((ROW > 1) ? (ROW - 2) : 0);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [LW-1:0] r_len;
  logic [LW-1:0] w_len_nxt;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] w_cnt_nxt;
  logic [LW-1:0] w_cnt_inc;
  logic [DW-1:0] r_drn;
  logic [DW-1:0] w_drn_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic          w_beat;

  assign vec_if.vec_ready = (r_state == StFeed);
  assign w_beat           = vec_if.vec_valid && vec_if.vec_ready;
  assign w_cnt_inc        = r_cnt + LW'(1);
  assign busy_o           = (r_state != StIdle);
  assign done_o           = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_drn_nxt   = r_drn;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_cnt_nxt = '0;
          w_drn_nxt = '0;
          if (len_i == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_len_nxt   = len_i;
            w_state_nxt = StFeed;
          end
        end
      end
      StFeed: begin
        if (w_beat) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_drn_nxt = '0;
            if (ROW == 1) begin
              w_state_nxt = StIdle;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = StDrain;
            end
          end
        end
      end
      StDrain: begin
        // The last vector reaches row ROW-1 on the same edge that leaves drain.
        if (r_drn == DrnLast) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end else begin
          w_drn_nxt = r_drn + DW'(1);
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_cnt   <= '0;
      r_drn   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drn   <= w_drn_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Per-row delay line: stage 0 captures the slot every cycle (bubble = zero data, no valid),
  // row r then passes through r more registers. The pipe never stalls.
  for (genvar g = 0; g < ROW; g++) begin : g_row
    logic [WIDTH-1:0] r_dat [g+1];
    logic             r_vld [g+1];

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        for (int k = 0; k <= g; k++) begin
          r_dat[k] <= '0;
          r_vld[k] <= 1'b0;
        end
      end else begin
        r_dat[0] <= w_beat ? vec_if.vec_data[g] : '0;
        r_vld[0] <= w_beat;
        for (int k = 1; k <= g; k++) begin
          r_dat[k] <= r_dat[k-1];
          r_vld[k] <= r_vld[k-1];
        end
      end
    end

    assign ib_data_o[g] = r_dat[g];
    assign row_vld_o[g] = r_vld[g];
  end

`ifdef SKEW_FEEDER_STATS_EN
  logic [15:0] r_bub;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bub <= '0;
    end else if ((r_state == StIdle) && start_i) begin
      r_bub <= '0;
    end else if ((r_state == StFeed) && !vec_if.vec_valid && (r_bub != 16'hFFFF)) begin
      r_bub <= r_bub + 16'd1;
    end
  end

  assign bubble_cnt_o = r_bub;
`endif

endmodule

// File: tb/tb_skew_input_feeder.sv
// tb_skew_input_feeder
//   Directed job sequence with randomized vector data and valid patterns. The reference model
//   keeps a per-cycle log of accepted vectors; row r's expected output is the vector accepted
//   r cycles before, and job state is tracked as remaining beats / remaining drain cycles.
module tb_skew_input_feeder;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned ROW     = 4;
  localparam int unsigned MAX_LEN = 256;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam int unsigned HIST    = 4096;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic                      start;
  logic [LW-1:0]             len;
  logic [ROW-1:0][WIDTH-1:0] ib_data;
  logic [ROW-1:0]            row_vld;
  logic                      busy;
  logic                      done;
`ifdef SKEW_FEEDER_STATS_EN
  logic [15:0]               bubble_cnt;
`endif

  always #5 clk = ~clk;

  skew_input_feeder_if #(.WIDTH(WIDTH), .ROW(ROW)) vif ();

  skew_input_feeder #(
    .WIDTH  (WIDTH),
    .ROW    (ROW),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (start),
    .len_i       (len),
    .vec_if      (vif.slave),
    .ib_data_o   (ib_data),
    .row_vld_o   (row_vld),
    .busy_o      (busy),
    .done_o      (done)
`ifdef SKEW_FEEDER_STATS_EN
    ,
    .bubble_cnt_o(bubble_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int                   n = 0;
  logic [ROW*WIDTH-1:0] s_dat [HIST];
  logic                 s_v   [HIST];
  int                   m_left  = 0;
  int                   m_drain = 0;
  logic                 m_done  = 1'b0;
  int                   m_bub   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_outputs();
    logic [ROW-1:0][WIDTH-1:0] ed;
    logic [ROW-1:0]            ev;
    logic [ROW*WIDTH-1:0]      slot;
    for (int r = 0; r < ROW; r++) begin
      if (n >= r) begin
        slot  = s_dat[(n - r) % HIST];
        ed[r] = slot[r*WIDTH +: WIDTH];
        ev[r] = s_v[(n - r) % HIST];
      end else begin
        ed[r] = '0;
        ev[r] = 1'b0;
      end
    end
    chk("ib_data", ib_data, ed);
    chk("row_vld", row_vld, ev);
    chk("busy", busy, (m_left > 0) || (m_drain > 0));
    chk("done", done, m_done);
    chk("vec_ready", vif.vec_ready, m_left > 0);
`ifdef SKEW_FEEDER_STATS_EN
    chk("bubble_cnt", bubble_cnt, m_bub);
`endif
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock and compare.
  task automatic step();
    logic beat;
    beat = vif.vec_valid && (m_left > 0);
    n++;
    s_dat[n % HIST] = beat ? vif.vec_data : '0;
    s_v[n % HIST]   = beat;
    m_done = 1'b0;
    if ((m_left == 0) && (m_drain == 0)) begin
      if (start) begin
        m_bub = 0;
        if (len == '0) m_done = 1'b1;
        else m_left = int'(len);
      end
    end else if (m_left > 0) begin
      if (!vif.vec_valid && (m_bub < 65535)) m_bub++;
      if (beat) begin
        m_left--;
        if (m_left == 0) begin
          m_drain = ROW - 1;
          if (m_drain == 0) m_done = 1'b1;
        end
      end
    end else begin
      m_drain--;
      if (m_drain == 0) m_done = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_step();
    start = 1'b0;
    vif.vec_valid = 1'($urandom_range(0, 1));
    vif.vec_data  = $urandom;
    step();
  endtask

  // vmode: 0 valid always high, 1 random valid, 2 valid low only on the 2nd feed cycle.
  // Returns right after the done cycle so a following call starts back-to-back.
  task automatic run_job(input int l, input int vmode, input bit poke,
                         input bit use_fd, input logic [31:0] fd);
    int  fc;
    int  guard;
    bit  was_feed;
    start = 1'b1;
    len   = LW'(l);
    vif.vec_valid = (vmode == 0);
    vif.vec_data  = use_fd ? fd : $urandom;
    step();
    start = 1'b0;
    fc    = 0;
    guard = 0;
    while (((m_left > 0) || (m_drain > 0)) && (guard < 2000)) begin
      case (vmode)
        0:       vif.vec_valid = 1'b1;
        1:       vif.vec_valid = ($urandom_range(0, 3) != 0);
        default: vif.vec_valid = (fc != 1);
      endcase
      vif.vec_data = use_fd ? fd : $urandom;
      if (poke && (guard == 2)) begin
        start = 1'b1;
        len   = LW'(2);
      end else begin
        start = 1'b0;
      end
      was_feed = (m_left > 0);
      step();
      if (was_feed) fc++;
      guard++;
    end
    start = 1'b0;
  endtask

  task automatic reset_mid_feed();
    start = 1'b1;
    len   = LW'(10);
    vif.vec_valid = 1'b1;
    step();
    start = 1'b0;
    repeat (3) begin
      vif.vec_data = $urandom;
      step();
    end
    #2;
    rstn = 1'b0;
    #1;
    m_left  = 0;
    m_drain = 0;
    m_done  = 1'b0;
    m_bub   = 0;
    for (int k = 0; k < ROW; k++) begin
      if (n >= k) begin
        s_dat[(n - k) % HIST] = '0;
        s_v[(n - k) % HIST]   = 1'b0;
      end
    end
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rstn = 1'b1;
    vif.vec_valid = 1'b0;
    step();
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    len   = '0;
    vif.vec_valid = 1'b0;
    vif.vec_data  = '0;
    for (int i = 0; i < HIST; i++) begin
      s_dat[i] = '0;
      s_v[i]   = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rstn = 1'b1;
    idle_step();

    // Single vector: row r shows element r, r cycles after row 0; done with the row-3 value.
    run_job(1, 0, 1'b0, 1'b1, 32'h0403_0201);
    idle_step();

    run_job(3, 0, 1'b0, 1'b0, '0);
    idle_step();

    // Bubble on the second feed cycle.
    run_job(3, 2, 1'b0, 1'b0, '0);
    idle_step();

    // Zero-length job: done next cycle, never busy.
    run_job(0, 1, 1'b0, 1'b0, '0);
    idle_step();

    // A start pulse while busy must be ignored.
    run_job(5, 1, 1'b1, 1'b0, '0);
    idle_step();

    reset_mid_feed();
    run_job(2, 1, 1'b0, 1'b0, '0);
    idle_step();

    repeat (5) begin
      run_job($urandom_range(1, 12), 1, 1'($urandom_range(0, 1)), 1'b0, '0);
    end
    idle_step();

    // Max-length jobs back to back, second start in the done cycle.
    run_job(MAX_LEN, 0, 1'b0, 1'b0, '0);
    run_job(MAX_LEN, 0, 1'b0, 1'b0, '0);
    repeat (3) idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
